sync_bank: RTL and testbench



---
 rtl/sync_bank_if.sv | 45 ++++
 rtl/sync_bank.sv | 129 ++++++++++++
 tb/tb_sync_bank.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_bank_if.sv
// ---------------------------------------------------------------------------
// sync_bank_if -- signal bundle for the sync_bank input synchronizer.
//
// Purpose : carries the per-channel pad inputs into the synchronizer and the
//           filtered levels and edge pulses back out to the consumer.
// Signals : async_in   (master -> slave) N_CH asynchronous pad inputs
//           sync_out   (slave -> master) N_CH filtered, synchronized levels
//           rise_pulse (slave -> master) N_CH one-cycle 0->1 pulses
//           fall_pulse (slave -> master) N_CH one-cycle 1->0 pulses
//           evt_clr    (master -> slave) N_CH sticky-flag clears   [SYNC_BANK_STICKY_EN]
//           evt_flag   (slave -> master) N_CH sticky event flags   [SYNC_BANK_STICKY_EN]
// Build   : define SYNC_BANK_STICKY_EN to add the sticky event flag signals.
// ---------------------------------------------------------------------------
interface sync_bank_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] async_in;
    logic [N_CH-1:0] sync_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
`ifdef SYNC_BANK_STICKY_EN
    logic [N_CH-1:0] evt_clr;
    logic [N_CH-1:0] evt_flag;
`endif

`ifdef SYNC_BANK_STICKY_EN
    modport master (
        output async_in, evt_clr,
        input  sync_out, rise_pulse, fall_pulse, evt_flag
    );
    modport slave (
        input  async_in, evt_clr,
        output sync_out, rise_pulse, fall_pulse, evt_flag
    );
`else
    modport master (
        output async_in,
        input  sync_out, rise_pulse, fall_pulse
    );
    modport slave (
        input  async_in,
        output sync_out, rise_pulse, fall_pulse
    );
`endif
endinterface

// File: rtl/sync_bank.sv
// ---------------------------------------------------------------------------
// sync_bank -- multi-channel CDC input synchronizer with glitch filter and
//              registered edge pulses.
//
// Purpose : each of N_CH single-bit pad inputs passes through a STAGES-deep
//           flop chain, then a stability filter that only lets a new level
//           through after it has persisted FILTER_LEN consecutive cycles.
//           Registered rise/fall pulses mark the first cycle of each new level.
// Ports   : clk    -- single clock, everything on its rising edge
//           reset  -- synchronous, active-high
//           bus    -- sync_bank_if.slave (async_in in; sync_out, rise_pulse,
//                     fall_pulse out; evt_clr in / evt_flag out when sticky)
// Params  : N_CH, STAGES (>=2), FILTER_LEN (>=1, 1 = no filtering),
//           RESET_VAL (per-channel reset level of chain and sync_out)
// Build   : define SYNC_BANK_STICKY_EN for per-channel sticky event flags that
//           set the cycle after any pulse and clear on evt_clr (set wins).
// ---------------------------------------------------------------------------
module sync_bank #(
    parameter int              N_CH       = 3,
    parameter int              STAGES     = 3,
    parameter int              FILTER_LEN = 1,
    parameter logic [N_CH-1:0] RESET_VAL  = '0
) (
    input  logic        clk,
    input  logic        reset,
    sync_bank_if.slave  bus
);

    localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [N_CH-1:0]  chain_q [STAGES];
    logic [N_CH-1:0]  chain_d [STAGES];
    logic [N_CH-1:0]  raw;

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic [N_CH-1:0]  sync_out_q,   sync_out_d;
    logic [N_CH-1:0]  rise_pulse_q, rise_pulse_d;
    logic [N_CH-1:0]  fall_pulse_q, fall_pulse_d;

    // Synchronizer chain: stage 0 is the only flop that sees the pad directly.
    always_comb begin
        chain_d[0] = bus.async_in;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    assign raw = chain_q[STAGES-1];

    // Stability filter and edge detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the branches below can leave it unassigned (no latches).
        sync_out_d = sync_out_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (raw[ch] == sync_out_q[ch]) begin
                // Matching level: any partial count was a glitch, discard it.
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                // New level has now been seen FILTER_LEN times in a row.
                sync_out_d[ch] = raw[ch];
                cnt_d[ch]      = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
        // Pulses are registered, so they appear together with the new level.
        rise_pulse_d =  sync_out_d & ~sync_out_q;
        fall_pulse_d = ~sync_out_d &  sync_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the chain stages form an array but are deliberately reset
            // to RESET_VAL, so a pad already at its reset level never
            // produces a spurious pulse after reset release.
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= RESET_VAL;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
            sync_out_q   <= RESET_VAL;
            rise_pulse_q <= '0;
            fall_pulse_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours.
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            sync_out_q   <= sync_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    assign bus.sync_out   = sync_out_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.fall_pulse = fall_pulse_q;

`ifdef SYNC_BANK_STICKY_EN
    logic [N_CH-1:0] evt_flag_q, evt_flag_d;

    // A pulse visible this cycle sets the flag at the next edge; a set
    // arriving on the same edge as a clear takes priority.
    always_comb begin
        evt_flag_d = (evt_flag_q & ~bus.evt_clr) | rise_pulse_q | fall_pulse_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_flag_q <= '0;
        end else begin
            evt_flag_q <= evt_flag_d;
        end
    end

    assign bus.evt_flag = evt_flag_q;
`endif

endmodule

// File: tb/tb_sync_bank.sv
// ---------------------------------------------------------------------------
// tb_sync_bank -- self-checking bench for sync_bank.
//
// Three instances run side by side on one clock and one reset:
//   u0 : defaults            (N_CH=3, STAGES=3, FILTER_LEN=1, RESET_VAL=0)
//   u1 : slow filter         (N_CH=3, STAGES=2, FILTER_LEN=4, RESET_VAL=0)
//   u2 : wide, reset high    (N_CH=8, STAGES=3, FILTER_LEN=1, RESET_VAL=FF)
// A reference model tracks each instance as "input delayed by STAGES edges,
// then a level must differ for FILTER_LEN consecutive edges before it is
// accepted"; every tick compares all instances against it.
// ---------------------------------------------------------------------------
module tb_sync_bank;

    logic clk;
    logic reset;
    logic [2:0] clr0, clr1;
    logic [7:0] clr2;

    int n_total = 0;
    int n_pass  = 0;

    sync_bank_if #(.N_CH(3)) if0 ();
    sync_bank_if #(.N_CH(3)) if1 ();
    sync_bank_if #(.N_CH(8)) if2 ();

`ifdef SYNC_BANK_STICKY_EN
    assign if0.evt_clr = clr0;
    assign if1.evt_clr = clr1;
    assign if2.evt_clr = clr2;
`endif

    sync_bank #(.N_CH(3), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(3'b000))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    sync_bank #(.N_CH(3), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(3'b000))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    sync_bank #(.N_CH(8), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(8'hFF))
        u2 (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         p_stages [3] = '{3, 2, 3};
    int         p_flen   [3] = '{1, 4, 1};
    logic [7:0] p_rv     [3] = '{8'h00, 8'h00, 8'hFF};

    logic [7:0] m_age    [3][4];   // m_age[d][j]: input sampled j+1 edges ago
    int         m_streak [3][8];   // consecutive edges raw differed from out
    logic [7:0] m_out    [3];
    logic [7:0] m_rise   [3];
    logic [7:0] m_fall   [3];
    logic [7:0] m_flag   [3];

    task automatic model_step(input int d, input logic [7:0] in,
                              input logic rst, input logic [7:0] clr);
        logic [7:0] raw;
        logic [7:0] nxt;
        if (rst) begin
            for (int j = 0; j < 4; j++) m_age[d][j] = p_rv[d];
            for (int c = 0; c < 8; c++) m_streak[d][c] = 0;
            m_out[d]  = p_rv[d];
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_flag[d] = '0;
            return;
        end
        raw = m_age[d][p_stages[d]-1];
        m_flag[d] = (m_flag[d] & ~clr) | m_rise[d] | m_fall[d];
        nxt = m_out[d];
        for (int c = 0; c < 8; c++) begin
            if (raw[c] != m_out[d][c]) begin
                m_streak[d][c]++;
                if (m_streak[d][c] == p_flen[d]) begin
                    nxt[c] = raw[c];
                    m_streak[d][c] = 0;
                end
            end else begin
                m_streak[d][c] = 0;
            end
        end
        m_rise[d] = nxt & ~m_out[d];
        m_fall[d] = ~nxt & m_out[d];
        m_out[d]  = nxt;
        for (int j = 3; j > 0; j--) m_age[d][j] = m_age[d][j-1];
        m_age[d][0] = in;
    endtask

    always @(posedge clk) begin
        model_step(0, {5'b0, if0.async_in}, reset, {5'b0, clr0});
        model_step(1, {5'b0, if1.async_in}, reset, {5'b0, clr1});
        model_step(2, if2.async_in,         reset, clr2);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        check("u0 sync_out",   {29'b0, if0.sync_out},   {29'b0, m_out[0][2:0]});
        check("u0 rise_pulse", {29'b0, if0.rise_pulse}, {29'b0, m_rise[0][2:0]});
        check("u0 fall_pulse", {29'b0, if0.fall_pulse}, {29'b0, m_fall[0][2:0]});
        check("u1 sync_out",   {29'b0, if1.sync_out},   {29'b0, m_out[1][2:0]});
        check("u1 rise_pulse", {29'b0, if1.rise_pulse}, {29'b0, m_rise[1][2:0]});
        check("u1 fall_pulse", {29'b0, if1.fall_pulse}, {29'b0, m_fall[1][2:0]});
        check("u2 sync_out",   {24'b0, if2.sync_out},   {24'b0, m_out[2]});
        check("u2 rise_pulse", {24'b0, if2.rise_pulse}, {24'b0, m_rise[2]});
        check("u2 fall_pulse", {24'b0, if2.fall_pulse}, {24'b0, m_fall[2]});
        check("u0 rise&fall",  {29'b0, if0.rise_pulse & if0.fall_pulse}, 32'd0);
        check("u2 rise&fall",  {24'b0, if2.rise_pulse & if2.fall_pulse}, 32'd0);
`ifdef SYNC_BANK_STICKY_EN
        check("u0 evt_flag",   {29'b0, if0.evt_flag},   {29'b0, m_flag[0][2:0]});
        check("u1 evt_flag",   {29'b0, if1.evt_flag},   {29'b0, m_flag[1][2:0]});
        check("u2 evt_flag",   {24'b0, if2.evt_flag},   {24'b0, m_flag[2]});
`endif
    endtask

    // One clock edge, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // ---------------- directed vectors for u0 ----------------
    typedef struct packed {
        logic [2:0] in;
        logic [2:0] sync;
        logic [2:0] rise;
        logic [2:0] fall;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // input applied before the edge, outputs expected after it
        vecs[0]  = '{3'b010, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{3'b010, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{3'b010, 3'b000, 3'b000, 3'b000};
        vecs[3]  = '{3'b010, 3'b010, 3'b010, 3'b000};  // edge 4: new level + rise
        vecs[4]  = '{3'b010, 3'b010, 3'b000, 3'b000};  // pulse lasts one cycle
        vecs[5]  = '{3'b000, 3'b010, 3'b000, 3'b000};
        vecs[6]  = '{3'b000, 3'b010, 3'b000, 3'b000};
        vecs[7]  = '{3'b000, 3'b010, 3'b000, 3'b000};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 3'b010};  // fall
        vecs[9]  = '{3'b101, 3'b000, 3'b000, 3'b000};
        vecs[10] = '{3'b101, 3'b000, 3'b000, 3'b000};
        vecs[11] = '{3'b101, 3'b000, 3'b000, 3'b000};
        vecs[12] = '{3'b111, 3'b101, 3'b101, 3'b000};  // two channels together
        vecs[13] = '{3'b111, 3'b101, 3'b000, 3'b000};
        vecs[14] = '{3'b111, 3'b101, 3'b000, 3'b000};
        vecs[15] = '{3'b111, 3'b111, 3'b010, 3'b000};
        vecs[16] = '{3'b111, 3'b111, 3'b000, 3'b000};
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        if0.async_in = '0;
        if1.async_in = '0;
        if2.async_in = '0;
        clr0 = '0;
        clr1 = '0;
        clr2 = '0;

        // Reset for two cycles, then quiet inputs: nothing may move on u0.
        repeat (2) tick();
        check("u0 reset sync_out", {29'b0, if0.sync_out}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("u0 idle sync_out", {29'b0, if0.sync_out}, 32'd0);
            check("u0 idle pulses", {26'b0, if0.rise_pulse, if0.fall_pulse}, 32'd0);
        end

        // Table-driven sequence on u0.
        for (int i = 0; i < 17; i++) begin
            if0.async_in = vecs[i].in;
            tick();
            check($sformatf("vec%0d sync_out", i),   {29'b0, if0.sync_out},   {29'b0, vecs[i].sync});
            check($sformatf("vec%0d rise_pulse", i), {29'b0, if0.rise_pulse}, {29'b0, vecs[i].rise});
            check($sformatf("vec%0d fall_pulse", i), {29'b0, if0.fall_pulse}, {29'b0, vecs[i].fall});
        end

        // u1: a 3-cycle glitch must be swallowed by FILTER_LEN=4.
        if1.async_in = 3'b001;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) if1.async_in = 3'b000;
            check("u1 glitch sync_out", {31'b0, if1.sync_out[0]}, 32'd0);
            check("u1 glitch rise", {31'b0, if1.rise_pulse[0]}, 32'd0);
        end

        // u1: a 4-cycle pulse reaches sync_out after edge 6 and leaves after edge 10.
        if1.async_in = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) if1.async_in = 3'b000;
            check($sformatf("u1 hold4 sync k=%0d", k), {31'b0, if1.sync_out[0]},
                  {31'b0, (k >= 6 && k <= 9) ? 1'b1 : 1'b0});
            check($sformatf("u1 hold4 rise k=%0d", k), {31'b0, if1.rise_pulse[0]},
                  {31'b0, (k == 6) ? 1'b1 : 1'b0});
            check($sformatf("u1 hold4 fall k=%0d", k), {31'b0, if1.fall_pulse[0]},
                  {31'b0, (k == 10) ? 1'b1 : 1'b0});
        end

        // u1: reset lands while the filter count sits at 2; the input then
        // needs a full STAGES+FILTER_LEN edges again.
        if1.async_in = 3'b001;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("u1 midcount reset sync", {29'b0, if1.sync_out}, 32'd0);
        check("u1 midcount reset pulses", {26'b0, if1.rise_pulse, if1.fall_pulse}, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("u1 post-reset sync k=%0d", k), {31'b0, if1.sync_out[0]},
                  {31'b0, (k >= 6) ? 1'b1 : 1'b0});
        end
        if1.async_in = 3'b000;

        // u2: RESET_VAL=FF released with inputs 0F: channels 0..3 stay high
        // silently, channels 4..7 fall; then dropping all inputs falls 0..3.
        reset = 1'b1;
        if2.async_in = 8'h0F;
        repeat (2) tick();
        check("u2 reset sync_out", {24'b0, if2.sync_out}, 32'hFF);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("u2 release rise", {24'b0, if2.rise_pulse}, 32'd0);
            check($sformatf("u2 release fall k=%0d", k), {24'b0, if2.fall_pulse},
                  (k == 4) ? 32'hF0 : 32'h00);
        end
        check("u2 settled sync_out", {24'b0, if2.sync_out}, 32'h0F);
        if2.async_in = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("u2 drop fall k=%0d", k), {24'b0, if2.fall_pulse},
                  (k == 4) ? 32'h0F : 32'h00);
        end

`ifdef SYNC_BANK_STICKY_EN
        // Sticky flag: set beats a simultaneous clear; a later clear alone wins.
        reset = 1'b1;
        if0.async_in = 3'b000;
        repeat (2) tick();
        reset = 1'b0;
        if0.async_in = 3'b100;
        repeat (4) tick();
        check("sticky rise ch2", {31'b0, if0.rise_pulse[2]}, 32'd1);
        check("sticky flag before set", {31'b0, if0.evt_flag[2]}, 32'd0);
        clr0 = 3'b100;
        tick();
        check("sticky set beats clr", {31'b0, if0.evt_flag[2]}, 32'd1);
        clr0 = 3'b000;
        tick();
        check("sticky holds", {31'b0, if0.evt_flag[2]}, 32'd1);
        clr0 = 3'b100;
        tick();
        check("sticky cleared", {31'b0, if0.evt_flag[2]}, 32'd0);
        clr0 = 3'b000;
`endif

        // Randomized run against the model; inputs change only occasionally
        // so that the slow filter sees both glitches and real transitions.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) if0.async_in = 3'($urandom);
            if ($urandom_range(0, 5) == 0) if1.async_in = 3'($urandom);
            if ($urandom_range(0, 2) == 0) if2.async_in = 8'($urandom);
            clr0 = 3'($urandom);
            clr1 = 3'($urandom);
            clr2 = 8'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
